// File: rtl/cordic_host_seq.sv
// Request sequencer for a single CORDIC core: issues one operation and reads
// both result halves back. The response goes out on a valid/ready stream.
module cordic_host_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mode,
    input  logic [9:0]         req_operand,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic signed [10:0] rsp_a,
    output logic signed [10:0] rsp_b,
    output logic               rsp_err,
    output logic               busy,
    output logic               core_rst,
    output logic               core_mode,
    output logic [9:0]         core_in_val,
    output logic               core_out_toggle,
    input  logic signed [10:0] core_val,
    input  logic               core_done
);

    localparam int unsigned OP_W  = 10;
    localparam int unsigned VAL_W = 11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        READ_A,
        READ_B,
        RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic signed [VAL_W-1:0]  rsp_a_q, rsp_a_d;
    logic signed [VAL_W-1:0]  rsp_b_q, rsp_b_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     busy_q, busy_d;
    logic                     core_rst_q, core_rst_d;
    logic                     core_mode_q, core_mode_d;
    logic [OP_W-1:0]          core_in_val_q, core_in_val_d;
    logic                     core_out_toggle_q, core_out_toggle_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            req_ready_q       <= 1'b1;
            rsp_valid_q       <= 1'b0;
            rsp_a_q           <= '0;
            rsp_b_q           <= '0;
            rsp_err_q         <= 1'b0;
            busy_q            <= 1'b0;
            core_rst_q        <= 1'b1;
            core_mode_q       <= 1'b0;
            core_in_val_q     <= '0;
            core_out_toggle_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            req_ready_q       <= req_ready_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_a_q           <= rsp_a_d;
            rsp_b_q           <= rsp_b_d;
            rsp_err_q         <= rsp_err_d;
            busy_q            <= busy_d;
            core_rst_q        <= core_rst_d;
            core_mode_q       <= core_mode_d;
            core_in_val_q     <= core_in_val_d;
            core_out_toggle_q <= core_out_toggle_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        req_ready_d       = req_ready_q;
        rsp_valid_d       = rsp_valid_q;
        rsp_a_d           = rsp_a_q;
        rsp_b_d           = rsp_b_q;
        rsp_err_d         = rsp_err_q;
        core_rst_d        = core_rst_q;
        core_mode_d       = core_mode_q;
        core_in_val_d     = core_in_val_q;
        core_out_toggle_d = core_out_toggle_q;

        case (state_q)
            IDLE: begin
                core_rst_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    core_mode_d   = req_mode;
                    core_in_val_d = req_operand;
                    cnt_d         = '0;
                    core_rst_d    = 1'b0;
                    req_ready_d   = 1'b0;
                    state_d       = RUN;
                end
            end
            RUN: begin
                // done wins over a timeout landing on the same cycle
                if (core_done) begin
                    core_out_toggle_d = 1'b1;
                    state_d           = READ_A;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d   = 1'b1;
                    rsp_a_d     = '0;
                    rsp_b_d     = '0;
                    core_rst_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ_A: begin
                rsp_a_d           = core_val;
                core_out_toggle_d = 1'b0;
                state_d           = READ_B;
            end
            READ_B: begin
                rsp_b_d     = core_val;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                core_rst_d  = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_a           = rsp_a_q;
    assign rsp_b           = rsp_b_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = busy_q;
    assign core_rst        = core_rst_q;
    assign core_mode       = core_mode_q;
    assign core_in_val     = core_in_val_q;
    assign core_out_toggle = core_out_toggle_q;

endmodule

// File: tb/tb_cordic_host_seq.sv
// Directed bench for cordic_host_seq with a cycle-accurate stand-in for the
// CORDIC core (done a fixed number of un-reset cycles after issue).
module tb_cordic_host_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_mode = 1'b0;
    logic [9:0]         req_operand = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic signed [10:0] rsp_a;
    logic signed [10:0] rsp_b;
    logic               rsp_err;
    logic               busy;
    logic               core_rst;
    logic               core_mode;
    logic [9:0]         core_in_val;
    logic               core_out_toggle;
    logic signed [10:0] core_val;
    logic               core_done;

    int checks = 0;
    int errors = 0;

    // core stand-in controls
    logic [4:0] step = '0;
    int         done_at = 5;
    bit         stuck = 1'b0;
    logic signed [10:0] stub_a, stub_b;

    cordic_host_seq #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
        .busy(busy), .core_rst(core_rst), .core_mode(core_mode),
        .core_in_val(core_in_val), .core_out_toggle(core_out_toggle),
        .core_val(core_val), .core_done(core_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_rst === 1'b1) step <= '0;
        else if (step != 5'd31) step <= step + 5'd1;
    end

    assign core_done = !stuck && (int'(step) >= done_at);

    // result table of the core stand-in, keyed on what the DUT presents
    always_comb begin
        stub_a = $signed({1'b0, core_in_val});
        stub_b = -$signed({1'b0, core_in_val}) - 11'sd1;
        if (!core_mode && core_in_val == 10'd0) begin
            stub_a = 11'sd0;   stub_b = 11'sd512;
        end else if (!core_mode && core_in_val == 10'd101) begin
            stub_a = 11'sd362; stub_b = 11'sd362;
        end else if (core_mode && core_in_val == 10'd528) begin
            stub_a = 11'sd402; stub_b = 11'sd373;
        end
        if (stuck) begin
            stub_a = 11'sd77;  stub_b = 11'sd99;
        end
    end

    assign core_val = core_out_toggle ? stub_a : stub_b;

    // Issue one request and wait for its response (left pending).
    task automatic run_op(input logic mode, input logic [9:0] op, output int lat,
                          output logic signed [10:0] a, output logic signed [10:0] b,
                          output logic err, output logic [15:0] tog, output bit stable);
        int g;
        @(negedge clk);
        req_mode = mode; req_operand = op; req_valid = 1'b1;
        g = 0;
        while (req_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; stable = 1'b1; tog = '0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (lat < 16) tog[lat] = core_out_toggle;
            if (core_in_val !== op || core_mode !== mode) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        a = rsp_a; b = rsp_b; err = rsp_err;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, core_rst, busy, rsp_valid, rsp_err, core_mode, core_out_toggle} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 1100000",
                     {req_ready, core_rst, busy, rsp_valid, rsp_err, core_mode, core_out_toggle});
        end
        checks++;
        if (core_in_val !== 10'd0 || rsp_a !== 11'sd0 || rsp_b !== 11'sd0) begin
            errors++;
            $display("FAIL reset_data got in=%0d a=%0d b=%0d want 0 0 0", core_in_val, rsp_a, rsp_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        run_op(1'b0, 10'd0, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 8 || a !== 11'sd0 || b !== 11'sd512 || err !== 1'b0) begin
            errors++;
            $display("FAIL rot0 got lat=%0d a=%0d b=%0d err=%b want 8 0 512 0", lat, a, b, err);
        end
        ack();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rot0_ack got v=%b rdy=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy);
        end
        run_op(1'b0, 10'd101, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 8 || a !== 11'sd362 || b !== 11'sd362 || err !== 1'b0) begin
            errors++;
            $display("FAIL rot45 got lat=%0d a=%0d b=%0d err=%b want 8 362 362 0", lat, a, b, err);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL rot45_stable got %b want 1", st);
        end
        ack();
    endtask

    task automatic test_vectoring();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        run_op(1'b1, {5'd16, 5'd16}, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 8 || a !== 11'sd402 || b !== 11'sd373 || err !== 1'b0) begin
            errors++;
            $display("FAIL vec got lat=%0d a=%0d b=%0d err=%b want 8 402 373 0", lat, a, b, err);
        end
        checks++;
        if (tog[7:0] !== 8'b0100_0000) begin
            errors++;
            $display("FAIL vec_toggle got %b want 01000000", tog[7:0]);
        end
        ack();
    endtask

    task automatic test_timeout();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        stuck = 1'b1;
        run_op(1'b0, 10'd200, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 15 || a !== 11'sd0 || b !== 11'sd0 || err !== 1'b1 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL timeout got lat=%0d a=%0d b=%0d err=%b crst=%b want 15 0 0 1 1",
                     lat, a, b, err, core_rst);
        end
        ack();
        stuck = 1'b0;
        run_op(1'b0, 10'd200, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 8 || a !== 11'sd200 || b !== -11'sd201 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout got lat=%0d a=%0d b=%0d err=%b want 8 200 -201 0", lat, a, b, err);
        end
        ack();
    endtask

    task automatic test_done_boundary();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        done_at = 14;
        run_op(1'b0, 10'd300, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 17 || a !== 11'sd300 || b !== -11'sd301 || err !== 1'b0) begin
            errors++;
            $display("FAIL done_last got lat=%0d a=%0d b=%0d err=%b want 17 300 -301 0", lat, a, b, err);
        end
        ack();
        done_at = 15;
        run_op(1'b0, 10'd300, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 15 || err !== 1'b1 || a !== 11'sd0) begin
            errors++;
            $display("FAIL done_late got lat=%0d err=%b a=%0d want 15 1 0", lat, err, a);
        end
        ack();
        done_at = 5;
    endtask

    task automatic test_throughput();
        int first, second, n;
        first = -1; second = -1; n = 0;
        @(negedge clk);
        req_mode = 1'b0; req_operand = 10'd101; req_valid = 1'b1; rsp_ready = 1'b1;
        while (second < 0 && n < 40) begin
            if (req_ready === 1'b1) begin
                if (first < 0) first = n; else second = n;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        checks++;
        if (second - first !== 10) begin
            errors++;
            $display("FAIL throughput got %0d cycles want 10", second - first);
        end
        while (busy === 1'b1 && n < 80) begin @(negedge clk); n++; end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        bit ok;
        run_op(1'b0, 10'd101, lat, a, b, err, tog, st);
        req_mode = 1'b0; req_operand = 10'd0; req_valid = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_a !== a || rsp_b !== b || rsp_err !== err || req_ready !== 1'b0)
                ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1 || a !== 11'sd362) begin
            errors++;
            $display("FAIL backpressure_hold got ok=%b a=%0d want 1 362", ok, a);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake got v=%b rdy=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || core_in_val !== 10'd0 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL next_accept got busy=%b rdy=%b in=%0d crst=%b want 1 0 0 0",
                     busy, req_ready, core_in_val, core_rst);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 8 || rsp_a !== 11'sd0 || rsp_b !== 11'sd512) begin
            errors++;
            $display("FAIL second_op got lat=%0d a=%0d b=%0d want 8 0 512", lat, rsp_a, rsp_b);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat; logic signed [10:0] a, b; logic err; logic [15:0] tog; bit st;
        bit seen;
        @(negedge clk);
        req_mode = 1'b0; req_operand = 10'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || core_rst !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_run got busy=%b crst=%b v=%b rdy=%b want 0 1 0 1",
                     busy, core_rst, rsp_valid, req_ready);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_stale got %b want 0", seen);
        end
        run_op(1'b0, 10'd101, lat, a, b, err, tog, st);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp got v=%b busy=%b crst=%b rdy=%b want 0 0 1 1",
                     rsp_valid, busy, core_rst, req_ready);
        end
        run_op(1'b1, {5'd16, 5'd16}, lat, a, b, err, tog, st);
        checks++;
        if (lat !== 8 || a !== 11'sd402 || b !== 11'sd373 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_rst got lat=%0d a=%0d b=%0d err=%b want 8 402 373 0", lat, a, b, err);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_timeout();
        test_done_boundary();
        test_throughput();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
